// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared types for the data-memory port arbiter: the transaction FSM states
// and the identity of the two requesters (instruction fetch and load/store).
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_LS = 1'b1
  } req_id_t;

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// rr_arbiter2
// Combinational 2-way round-robin pick between the fetch and load/store
// requesters.
// Ports:
//   if_req, ls_req : request levels from the two requesters
//   last_gnt       : requester that won the previous arbitration
//   valid          : at least one request is present
//   pick           : selected requester (only meaningful when valid=1)
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic    if_req,
  input  logic    ls_req,
  input  req_id_t last_gnt,
  output logic    valid,
  output req_id_t pick
);

  // A lone request always wins; on a conflict the requester that did not win
  // last time gets the port, so neither side can starve the other.
  always_comb begin
    valid = if_req | ls_req;
    pick  = REQ_IF;
    if (if_req && ls_req) begin
      pick = (last_gnt == REQ_IF) ? REQ_LS : REQ_IF;
    end else if (ls_req) begin
      pick = REQ_LS;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single 64-bit data memory port between instruction fetch (IF)
// and load/store (LS). Each accepted request is sequenced as
// IDLE -> ISSUE -> WAIT -> RESP -> IDLE (stores go ISSUE -> RESP directly).
// Ports:
//   clock, reset          : single clock, synchronous active-high reset
//   if_req/if_addr        : fetch request level and byte address
//   if_gnt/if_done        : 1-cycle accept / data-valid pulses for fetch
//   if_rdata              : 32-bit instruction word picked by address bit 2
//   ls_req/ls_we/ls_addr/ls_wdata : load/store request, direction, operands
//   ls_gnt/ls_done        : 1-cycle accept / complete pulses for load/store
//   ls_rdata              : load data, zero after a store
//   mem_addr/mem_wdata/mem_wr/mem_rdata : memory port
//   busy                  : high whenever a transaction is in progress
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int MEM_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_done,
  output logic [31:0]       if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_done,
  output logic [DATA_W-1:0] ls_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  generate
    if (MEM_LAT < 1) begin : g_bad_lat
      $error("mem_port_arbiter: MEM_LAT must be >= 1");
    end
    if (DATA_W < 64) begin : g_bad_data
      $error("mem_port_arbiter: DATA_W must be at least 64");
    end
    if (ADDR_W < 3) begin : g_bad_addr
      $error("mem_port_arbiter: ADDR_W must be at least 3");
    end
  endgenerate

  state_t             state_q;
  state_t             state_n;
  req_id_t            last_gnt_q;
  req_id_t            sel_q;
  logic [ADDR_W-1:0]  addr_q;
  logic               we_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               half_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               arb_valid;
  req_id_t            arb_pick;

  rr_arbiter2 u_rr (
    .if_req   (if_req),
    .ls_req   (ls_req),
    .last_gnt (last_gnt_q),
    .valid    (arb_valid),
    .pick     (arb_pick)
  );

  // Next-state logic. Loads and fetches always spend MEM_LAT cycles in WAIT;
  // the last WAIT cycle is the one in which mem_rdata is sampled, so the
  // response reaches the requester MEM_LAT+2 cycles after the request was
  // seen in IDLE. Requests are only looked at in IDLE.
  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    if (arb_valid) state_n = ISSUE;
      ISSUE:   state_n = we_q ? RESP : WAIT;
      WAIT:    if (cnt_q == '0) state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State register plus the transaction datapath. The operand latches are
  // loaded only on the accepting edge out of IDLE, so the memory port keeps
  // showing the last transaction while idle. The read data register and the
  // word-half select are loaded together on the edge into RESP so both
  // rdata outputs stay stable until the next response.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      last_gnt_q <= REQ_LS;
      sel_q      <= REQ_IF;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      half_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q <= state_n;
      case (state_q)
        IDLE: begin
          if (arb_valid) begin
            sel_q      <= arb_pick;
            last_gnt_q <= arb_pick;
            if (arb_pick == REQ_LS) begin
              addr_q  <= ls_addr;
              we_q    <= ls_we;
              wdata_q <= ls_wdata;
            end else begin
              addr_q  <= if_addr;
              we_q    <= 1'b0;
            end
          end
        end
        ISSUE: begin
          if (we_q) begin
            rdata_q <= '0;
            half_q  <= addr_q[2];
          end else begin
            cnt_q <= CNT_W'(MEM_LAT - 1);
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            rdata_q <= mem_rdata;
            half_q  <= addr_q[2];
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Handshake pulses and memory strobes are decoded from the state and the
  // latched requester id, so only one gnt and one done can ever be high.
  always_comb begin
    if_gnt  = 1'b0;
    ls_gnt  = 1'b0;
    if_done = 1'b0;
    ls_done = 1'b0;
    mem_wr  = 1'b0;
    busy    = (state_q != IDLE);
    if (state_q == ISSUE) begin
      if_gnt = (sel_q == REQ_IF);
      ls_gnt = (sel_q == REQ_LS);
      mem_wr = we_q;
    end
    if (state_q == RESP) begin
      if_done = (sel_q == REQ_IF);
      ls_done = (sel_q == REQ_LS);
    end
  end

  // Data outputs come straight from the latched registers.
  always_comb begin
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    ls_rdata  = rdata_q;
    if_rdata  = half_q ? rdata_q[63:32] : rdata_q[31:0];
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter. Two instances share all inputs: one
// with MEM_LAT=1 and one with MEM_LAT=3, each attached to its own small
// memory model whose read data appears MEM_LAT clocks after the address.
module tb_mem_port_arbiter;

  logic        clock;
  logic        reset;
  logic        if_req;
  logic [63:0] if_addr;
  logic        ls_req;
  logic        ls_we;
  logic [63:0] ls_addr;
  logic [63:0] ls_wdata;

  logic        if_gnt_1, if_done_1, ls_gnt_1, ls_done_1, mem_wr_1, busy_1;
  logic [31:0] if_rdata_1;
  logic [63:0] ls_rdata_1, mem_addr_1, mem_wdata_1, mem_rdata_1;

  logic        if_gnt_3, if_done_3, ls_gnt_3, ls_done_3, mem_wr_3, busy_3;
  logic [31:0] if_rdata_3;
  logic [63:0] ls_rdata_3, mem_addr_3, mem_wdata_3, mem_rdata_3;

  int tests;
  int failed;

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(1)) dut1 (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_1),
    .if_done(if_done_1), .if_rdata(if_rdata_1),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt_1), .ls_done(ls_done_1), .ls_rdata(ls_rdata_1),
    .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1), .mem_wr(mem_wr_1),
    .mem_rdata(mem_rdata_1), .busy(busy_1)
  );

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(3)) dut3 (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_3),
    .if_done(if_done_3), .if_rdata(if_rdata_3),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt_3), .ls_done(ls_done_3), .ls_rdata(ls_rdata_3),
    .mem_addr(mem_addr_3), .mem_wdata(mem_wdata_3), .mem_wr(mem_wr_3),
    .mem_rdata(mem_rdata_3), .busy(busy_3)
  );

  // Free-running clock, period 10.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory models: 32 doublewords each, word 2 (byte 0x10) preloaded while
  // reset is high, writes on mem_wr, read data through a MEM_LAT-deep pipe.
  logic [63:0] mem1 [0:31];
  logic [63:0] mem3 [0:31];
  logic [63:0] rd1_q;
  logic [63:0] rd3_q [0:2];

  always @(posedge clock) begin
    if (reset) mem1[2] <= 64'h11112222_33334444;
    else if (mem_wr_1) mem1[mem_addr_1[7:3]] <= mem_wdata_1;
    rd1_q <= mem1[mem_addr_1[7:3]];
  end

  always @(posedge clock) begin
    if (reset) mem3[2] <= 64'h11112222_33334444;
    else if (mem_wr_3) mem3[mem_addr_3[7:3]] <= mem_wdata_3;
    rd3_q[0] <= mem3[mem_addr_3[7:3]];
    rd3_q[1] <= rd3_q[0];
    rd3_q[2] <= rd3_q[1];
  end

  assign mem_rdata_1 = rd1_q;
  assign mem_rdata_3 = rd3_q[2];

  // One comparison: counts it, and reports tag/observed/expected on failure.
  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic ifr, input logic [63:0] ifa,
                               input logic lsr, input logic we,
                               input logic [63:0] lsa, input logic [63:0] wd);
    if_req   = ifr;
    if_addr  = ifa;
    ls_req   = lsr;
    ls_we    = we;
    ls_addr  = lsa;
    ls_wdata = wd;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Mutual exclusion of the handshake pulses, sampled mid-cycle.
  always @(negedge clock) begin
    if (!reset) begin
      checkOutput("gnt_excl_1",  {63'd0, if_gnt_1 & ls_gnt_1},   64'd0);
      checkOutput("done_excl_1", {63'd0, if_done_1 & ls_done_1}, 64'd0);
      checkOutput("gnt_excl_3",  {63'd0, if_gnt_3 & ls_gnt_3},   64'd0);
      checkOutput("done_excl_3", {63'd0, if_done_3 & ls_done_3}, 64'd0);
    end
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int      n;
    logic    seq [4];
    tests  = 0;
    failed = 0;
    reset  = 1'b1;
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0);
    tick();
    tick();

    // Reset state.
    checkOutput("rst_busy",   {63'd0, busy_1},   64'd0);
    checkOutput("rst_gnt",    {62'd0, if_gnt_1, ls_gnt_1},   64'd0);
    checkOutput("rst_done",   {62'd0, if_done_1, ls_done_1}, 64'd0);
    checkOutput("rst_mem_wr", {63'd0, mem_wr_1}, 64'd0);
    checkOutput("rst_addr",   mem_addr_1, 64'd0);
    checkOutput("rst_rdata",  ls_rdata_1, 64'd0);
    reset = 1'b0;
    tick();

    // Fetch of the low word at 0x10.
    applyStimulus(1'b1, 64'h10, 1'b0, 1'b0, 64'h0, 64'h0);
    tick();
    checkOutput("f1_gnt",    {63'd0, if_gnt_1}, 64'd1);
    checkOutput("f1_lsgnt",  {63'd0, ls_gnt_1}, 64'd0);
    checkOutput("f1_addr",   mem_addr_1, 64'h10);
    checkOutput("f1_wr",     {63'd0, mem_wr_1}, 64'd0);
    checkOutput("f1_busy",   {63'd0, busy_1},   64'd1);
    applyStimulus(1'b0, 64'h10, 1'b0, 1'b0, 64'h0, 64'h0);
    tick();
    checkOutput("f1_early",  {63'd0, if_done_1}, 64'd0);
    tick();
    checkOutput("f1_done",   {63'd0, if_done_1}, 64'd1);
    checkOutput("f1_rdata",  {32'd0, if_rdata_1}, 64'h33334444);
    tick();
    checkOutput("f1_idle",   {63'd0, busy_1},   64'd0);
    checkOutput("f1_hold",   {32'd0, if_rdata_1}, 64'h33334444);

    // Fetch of the high word at 0x14.
    applyStimulus(1'b1, 64'h14, 1'b0, 1'b0, 64'h0, 64'h0);
    tick();
    checkOutput("f2_gnt",    {63'd0, if_gnt_1}, 64'd1);
    applyStimulus(1'b0, 64'h14, 1'b0, 1'b0, 64'h0, 64'h0);
    tick();
    tick();
    checkOutput("f2_done",   {63'd0, if_done_1}, 64'd1);
    checkOutput("f2_rdata",  {32'd0, if_rdata_1}, 64'h11112222);
    tick();

    // Load of 0x10 via LS, so ls_rdata is non-zero before the store.
    applyStimulus(1'b0, 64'h0, 1'b1, 1'b0, 64'h10, 64'h0);
    tick();
    checkOutput("l0_gnt",    {63'd0, ls_gnt_1}, 64'd1);
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 64'h10, 64'h0);
    tick();
    tick();
    checkOutput("l0_done",   {63'd0, ls_done_1}, 64'd1);
    checkOutput("l0_rdata",  ls_rdata_1, 64'h11112222_33334444);
    tick();

    // Store to 0x40, then load it back.
    applyStimulus(1'b0, 64'h0, 1'b1, 1'b1, 64'h40, 64'hDEADBEEF_CAFEF00D);
    tick();
    checkOutput("st_gnt",    {63'd0, ls_gnt_1}, 64'd1);
    checkOutput("st_wr",     {63'd0, mem_wr_1}, 64'd1);
    checkOutput("st_addr",   mem_addr_1,  64'h40);
    checkOutput("st_wdata",  mem_wdata_1, 64'hDEADBEEF_CAFEF00D);
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0);
    tick();
    checkOutput("st_wr_off", {63'd0, mem_wr_1}, 64'd0);
    checkOutput("st_done",   {63'd0, ls_done_1}, 64'd1);
    checkOutput("st_rdata",  ls_rdata_1, 64'd0);
    tick();
    checkOutput("st_idle",   {63'd0, busy_1}, 64'd0);
    applyStimulus(1'b0, 64'h0, 1'b1, 1'b0, 64'h40, 64'h0);
    tick();
    checkOutput("lb_gnt",    {63'd0, ls_gnt_1}, 64'd1);
    checkOutput("lb_wr",     {63'd0, mem_wr_1}, 64'd0);
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0);
    tick();
    tick();
    checkOutput("lb_done",   {63'd0, ls_done_1}, 64'd1);
    checkOutput("lb_rdata",  ls_rdata_1, 64'hDEADBEEF_CAFEF00D);
    tick();

    // Both requests held high after reset: grants alternate IF, LS, IF, LS.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    applyStimulus(1'b1, 64'h10, 1'b1, 1'b0, 64'h40, 64'h0);
    n = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (if_gnt_1 && n < 4) begin seq[n] = 1'b0; n++; end
      if (ls_gnt_1 && n < 4) begin seq[n] = 1'b1; n++; end
    end
    checkOutput("rr_count", n, 64'd4);
    checkOutput("rr_0", {63'd0, seq[0]}, 64'd0);
    checkOutput("rr_1", {63'd0, seq[1]}, 64'd1);
    checkOutput("rr_2", {63'd0, seq[2]}, 64'd0);
    checkOutput("rr_3", {63'd0, seq[3]}, 64'd1);
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0);
    repeat (8) tick();

    // MEM_LAT=3 load: gnt at T+1, done exactly at T+5, busy T+1..T+5.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    applyStimulus(1'b0, 64'h0, 1'b1, 1'b0, 64'h10, 64'h0);
    tick();
    checkOutput("l3_gnt",  {63'd0, ls_gnt_3}, 64'd1);
    checkOutput("l3_busy1", {63'd0, busy_3},  64'd1);
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0);
    for (int c = 2; c <= 4; c++) begin
      tick();
      checkOutput($sformatf("l3_busy%0d", c), {63'd0, busy_3},    64'd1);
      checkOutput($sformatf("l3_nodone%0d", c), {63'd0, ls_done_3}, 64'd0);
    end
    tick();
    checkOutput("l3_done",  {63'd0, ls_done_3}, 64'd1);
    checkOutput("l3_busy5", {63'd0, busy_3},    64'd1);
    checkOutput("l3_rdata", ls_rdata_3, 64'h11112222_33334444);
    tick();
    checkOutput("l3_idle",  {63'd0, busy_3},    64'd0);
    checkOutput("l3_after", {63'd0, ls_done_3}, 64'd0);

    // MEM_LAT=3, reset during WAIT discards the transaction.
    applyStimulus(1'b0, 64'h0, 1'b1, 1'b0, 64'h10, 64'h0);
    tick();
    checkOutput("r3_gnt", {63'd0, ls_gnt_3}, 64'd1);
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0);
    tick();
    reset = 1'b1;
    tick();
    checkOutput("r3_busy",  {63'd0, busy_3},    64'd0);
    checkOutput("r3_done",  {63'd0, ls_done_3}, 64'd0);
    checkOutput("r3_wr",    {63'd0, mem_wr_3},  64'd0);
    checkOutput("r3_rdata", ls_rdata_3, 64'd0);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput($sformatf("r3_quiet%0d", c), {62'd0, if_done_3, ls_done_3}, 64'd0);
    end
    applyStimulus(1'b1, 64'h14, 1'b1, 1'b0, 64'h10, 64'h0);
    tick();
    checkOutput("r3_ifgnt", {63'd0, if_gnt_3}, 64'd1);
    checkOutput("r3_lsgnt", {63'd0, ls_gnt_3}, 64'd0);
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0);
    repeat (6) tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
